// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM states and frame constants.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } xmit_state_e;

  localparam int   FRAME_DATA_BITS = 8;
  localparam logic LINE_IDLE       = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..BAUD_DIV-1 and wraps, flagging the last and
// second-to-last cycle of each serial bit.
module uart_baud_cnt #(
  parameter int BAUD_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic bit_end_o,
  output logic bit_pre_end_o
);

  localparam int W = $clog2(BAUD_DIV);

  logic [W-1:0] cnt_q;

  assign bit_end_o     = (cnt_q == W'(BAUD_DIV - 1));
  assign bit_pre_end_o = (cnt_q == W'(BAUD_DIV - 2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i || bit_end_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/uart_xmit_ctrl.sv
// UART transmit sequencer: one-deep holding buffer feeding a start/data/
// (parity)/stop serialiser, with registered line and status outputs.
module uart_xmit_ctrl
  import uart_pkg::*;
#(
  parameter int BAUD_DIV  = 16,
  parameter int PARITY_EN = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] din,
  output logic       wr_ready,
  output logic       ser_out,
  output logic       xmitting,
  output logic       done_xmitting
);

  xmit_state_e state_q;
  logic [7:0]  sh_q;
  logic [7:0]  buf_q;
  logic        buf_full_q;
  logic        par_q;
  logic [2:0]  idx_q;
  logic        ser_q;
  logic        xmit_q;
  logic        done_q;

  logic        bit_end;
  logic        bit_pre_end;
  logic        baud_clr;
  logic        accept;
  logic        bypass;
  logic [7:0]  next_byte;

  assign wr_ready      = ~buf_full_q;
  assign ser_out       = ser_q;
  assign xmitting      = xmit_q;
  assign done_xmitting = done_q;

  assign baud_clr  = (state_q == ST_IDLE);
  assign accept    = wr_en && !buf_full_q;
  // A write lands straight in the shift register when the serialiser is
  // about to take a byte this edge and nothing is already waiting.
  assign bypass    = (state_q == ST_IDLE) ||
                     ((state_q == ST_STOP) && bit_end && !buf_full_q);
  assign next_byte = buf_full_q ? buf_q : din;

  uart_baud_cnt #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk           (clk),
    .rst           (rst),
    .clr_i         (baud_clr),
    .bit_end_o     (bit_end),
    .bit_pre_end_o (bit_pre_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sh_q       <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      par_q      <= 1'b0;
      idx_q      <= '0;
      ser_q      <= LINE_IDLE;
      xmit_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept && !bypass) begin
        buf_q      <= din;
        buf_full_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          ser_q  <= LINE_IDLE;
          xmit_q <= 1'b0;
          if (accept) begin
            sh_q    <= next_byte;
            par_q   <= ^next_byte;
            state_q <= ST_START;
            ser_q   <= ~LINE_IDLE;
            xmit_q  <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state_q <= ST_DATA;
            idx_q   <= '0;
            ser_q   <= sh_q[0];
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (idx_q == 3'(FRAME_DATA_BITS - 1)) begin
              if (PARITY_EN != 0) begin
                state_q <= ST_PARITY;
                ser_q   <= par_q;
              end else begin
                state_q <= ST_STOP;
                ser_q   <= LINE_IDLE;
              end
            end else begin
              idx_q <= idx_q + 3'd1;
              sh_q  <= {1'b0, sh_q[7:1]};
              ser_q <= sh_q[1];
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            state_q <= ST_STOP;
            ser_q   <= LINE_IDLE;
          end
        end
        ST_STOP: begin
          done_q <= bit_pre_end;
          if (bit_end) begin
            if (buf_full_q || accept) begin
              sh_q       <= next_byte;
              par_q      <= ^next_byte;
              buf_full_q <= 1'b0;
              state_q    <= ST_START;
              ser_q      <= ~LINE_IDLE;
            end else begin
              state_q <= ST_IDLE;
              ser_q   <= LINE_IDLE;
              xmit_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ser_q   <= LINE_IDLE;
          xmit_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_xmit_ctrl.sv
// Scoreboard bench: a frame-schedule model predicts each byte's start cycle and
// buffer occupancy; a line receiver decodes both DUTs' serial output.
module tb_uart_xmit_ctrl;

  localparam int B   = 4;
  localparam int FL0 = 10 * B;
  localparam int FL1 = 11 * B;

  typedef struct {
    logic [7:0] b;
    int         s;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en [2];
  logic [7:0] din   [2];
  logic       ready [2];
  logic       ser   [2];
  logic       xm    [2];
  logic       dn    [2];

  always #5 clk = ~clk;

  uart_xmit_ctrl #(.BAUD_DIV(B), .PARITY_EN(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en[0]), .din(din[0]), .wr_ready(ready[0]),
    .ser_out(ser[0]), .xmitting(xm[0]), .done_xmitting(dn[0])
  );

  uart_xmit_ctrl #(.BAUD_DIV(B), .PARITY_EN(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en[1]), .din(din[1]), .wr_ready(ready[1]),
    .ser_out(ser[1]), .xmitting(xm[1]), .done_xmitting(dn[1])
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: per DUT, the last cycle of the latest scheduled frame and
  // the window of cycles in which the holding buffer is occupied.
  exp_t       exp_q [2][$];
  int         last_end [2];
  int         pend_lo  [2];
  int         pend_hi  [2];
  logic       exp_rdy  [2];
  logic       req_en   [2];
  logic [7:0] req_din  [2];
  logic       fin = 1'b0;

  int passed = 0;
  int total  = 0;

  function automatic int flen(input int d);
    return (d == 0) ? FL0 : FL1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      last_end[d] = -1000;
      pend_lo[d]  = 1;
      pend_hi[d]  = 0;
      exp_rdy[d]  = 1'b1;
      exp_q[d].delete();
    end
  endtask

  task automatic step();
    int   k;
    int   st;
    logic rdy;
    exp_t e;
    k = cyc;
    for (int d = 0; d < 2; d++) begin
      rdy        = !(pend_lo[d] <= k && k <= pend_hi[d]);
      exp_rdy[d] = rdy;
      wr_en[d]   = req_en[d];
      din[d]     = req_din[d];
      if (req_en[d] && rdy) begin
        st = (k + 1 > last_end[d] + 1) ? k + 1 : last_end[d] + 1;
        if (k < last_end[d]) begin
          pend_lo[d] = k + 1;
          pend_hi[d] = last_end[d];
        end
        e.b = req_din[d];
        e.s = st;
        exp_q[d].push_back(e);
        last_end[d] = st + flen(d) - 1;
      end
      req_en[d] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    step();
  endtask

  task automatic wr_tick(input int d, input logic [7:0] v);
    req_en[d]  = 1'b1;
    req_din[d] = v;
    tick();
  endtask

  task automatic drain();
    int m;
    m = (last_end[0] > last_end[1]) ? last_end[0] : last_end[1];
    while (cyc < m + 3) tick();
  endtask

  // Monitor / receiver
  logic samp [2][48];
  logic rx_on [2];
  int   rx_n [2];
  int   rx_st [2];
  int   rx_bad [2];

  task automatic chk(input int d, input string nm, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", nm, d, cyc, act, req);
  endtask

  task automatic frame_end(input int d);
    exp_t       e;
    logic [7:0] got;
    int         nbits;
    int         unstable;
    nbits    = flen(d) / B;
    unstable = 0;
    got      = '0;
    for (int j = 0; j < nbits; j++)
      for (int t = 0; t < B; t++)
        if (samp[d][j*B+t] !== samp[d][j*B]) unstable++;
    for (int i = 0; i < 8; i++) got[i] = samp[d][(i+1)*B];
    if (exp_q[d].size() == 0) begin
      total++;
      $display("FAIL unexpected_frame dut%0d cycle %0d: got byte %02h expected none", d, cyc, got);
      return;
    end
    e = exp_q[d].pop_front();
    chk(d, "data_byte", int'(got), int'(e.b));
    chk(d, "start_cycle", rx_st[d], e.s);
    chk(d, "bit_stable", unstable, 0);
    chk(d, "xmit_done_ctl", rx_bad[d], 0);
    chk(d, "stop_bit", int'(samp[d][(nbits-1)*B]), 1);
    if (d == 1) chk(d, "parity_bit", int'(samp[d][9*B]), int'(^e.b));
  endtask

  task automatic mon(input int d);
    if (rst) begin
      chk(d, "rst_ser", int'(ser[d]), 1);
      chk(d, "rst_xmitting", int'(xm[d]), 0);
      chk(d, "rst_ready", int'(ready[d]), 1);
      chk(d, "rst_done", int'(dn[d]), 0);
      rx_on[d] = 1'b0;
      return;
    end
    chk(d, "wr_ready", int'(ready[d]), int'(exp_rdy[d]));
    if (!rx_on[d] && ser[d] === 1'b0) begin
      rx_on[d]  = 1'b1;
      rx_n[d]   = 0;
      rx_st[d]  = cyc;
      rx_bad[d] = 0;
    end
    if (rx_on[d]) begin
      samp[d][rx_n[d]] = ser[d];
      if (xm[d] !== 1'b1 || dn[d] !== (rx_n[d] == flen(d) - 1)) rx_bad[d]++;
      rx_n[d]++;
      if (rx_n[d] == flen(d)) begin
        frame_end(d);
        rx_on[d] = 1'b0;
      end
    end else begin
      chk(d, "idle_xmitting", int'(xm[d]), 0);
      chk(d, "idle_done", int'(dn[d]), 0);
    end
  endtask

  initial begin
    rx_on[0] = 1'b0;
    rx_on[1] = 1'b0;
  end

  always @(negedge clk) begin
    if (fin) begin
      for (int d = 0; d < 2; d++) chk(d, "frames_outstanding", exp_q[d].size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
    end else begin
      for (int d = 0; d < 2; d++) mon(d);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1);
  end

  initial begin
    int s;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      req_en[d]  = 1'b0;
      req_din[d] = '0;
      wr_en[d]   = 1'b0;
      din[d]     = '0;
    end
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    step();
    repeat (3) tick();

    // Single frame from idle
    wr_tick(0, 8'hA5);
    drain();

    // Buffered second byte, third write ignored while buffer full
    wr_tick(0, 8'h3C);
    repeat (10) tick();
    wr_tick(0, 8'h81);
    repeat (3) tick();
    wr_tick(0, 8'hFF);
    drain();

    // Parity frame
    wr_tick(1, 8'h07);
    drain();

    // Write landing exactly in the last STOP cycle with the buffer empty
    wr_tick(0, 8'h96);
    while (cyc < last_end[0] - 1) tick();
    wr_tick(0, 8'h69);
    drain();

    // Reset during DATA bit 3
    wr_tick(0, 8'h5A);
    s = cyc + 1;
    while (cyc < s + 4*B + 1) tick();
    rst = 1'b1;
    model_reset();
    repeat (2) tick();
    @(posedge clk);
    #2;
    rst = 1'b0;
    step();
    tick();
    wr_tick(0, 8'hC3);
    drain();

    // Randomised traffic on both channels
    for (int i = 0; i < 3000; i++) begin
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(0, 29) == 0) begin
          req_en[d]  = 1'b1;
          req_din[d] = 8'($urandom);
        end
      end
      tick();
    end
    drain();
    fin = 1'b1;
  end

endmodule
